// File: rtl/board_pkg.sv
// Shared types and constants for the board line-clear engine.
package board_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_COPY,
    ST_FILL,
    ST_DONE
  } state_e;

  localparam int EMPTY_ID   = 0;
  localparam int DEF_WIDTH  = 10;
  localparam int DEF_HEIGHT = 20;
  localparam int DEF_ID_W   = 3;

endpackage

// File: rtl/line_compactor_ctr.sv
// Control FSM for the line compactor: sequences CHECK/COPY/FILL and emits
// pointer/counter strobes; the datapath lives in the top level.
module line_compactor_ctr import board_pkg::*; (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   start_i,
  input  logic   last_col_i,
  input  logic   row_full_i,
  input  logic   src_zero_i,
  input  logic   src_eq_dst_i,
  input  logic   cnt_zero_i,
  output state_e state_o,
  output logic   load_o,
  output logic   src_dec_o,
  output logic   dst_dec_o,
  output logic   cnt_inc_o,
  output logic   fill_load_o
);

  state_e state_q, state_d;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and strobe decode; decisions are taken on the last column.
  always_comb begin
    state_d     = state_q;
    load_o      = 1'b0;
    src_dec_o   = 1'b0;
    dst_dec_o   = 1'b0;
    cnt_inc_o   = 1'b0;
    fill_load_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          load_o  = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (last_col_i) begin
          if (row_full_i) begin
            cnt_inc_o = 1'b1;
            if (src_zero_i) begin
              fill_load_o = 1'b1;
              state_d     = ST_FILL;
            end else begin
              src_dec_o = 1'b1;
            end
          end else if (!src_eq_dst_i) begin
            state_d = ST_COPY;
          end else if (src_zero_i) begin
            // Nothing to blank-fill when no row was removed.
            if (cnt_zero_i) begin
              state_d = ST_DONE;
            end else begin
              fill_load_o = 1'b1;
              state_d     = ST_FILL;
            end
          end else begin
            src_dec_o = 1'b1;
            dst_dec_o = 1'b1;
          end
        end
      end
      ST_COPY: begin
        if (last_col_i) begin
          if (src_zero_i) begin
            fill_load_o = 1'b1;
            state_d     = ST_FILL;
          end else begin
            src_dec_o = 1'b1;
            dst_dec_o = 1'b1;
            state_d   = ST_CHECK;
          end
        end
      end
      ST_FILL: begin
        if (last_col_i) begin
          if (src_zero_i) state_d = ST_DONE;
          else            src_dec_o = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/line_compactor.sv
// Multi-row line-clear engine: scans rows bottom-up, compacts surviving rows
// downward in place and blank-fills the freed rows at the top.
module line_compactor import board_pkg::*; #(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int HEIGHT  = DEF_HEIGHT,
  parameter  int ID_W    = DEF_ID_W,
  parameter  int TOTAL_W = 16,
  localparam int XW      = $clog2(WIDTH),
  localparam int YW      = $clog2(HEIGHT),
  localparam int CW      = $clog2(HEIGHT + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ID_W-1:0]    read_id,
  output logic [XW-1:0]      read_x,
  output logic [YW-1:0]      read_y,
  output logic [XW-1:0]      write_x,
  output logic [YW-1:0]      write_y,
  output logic [ID_W-1:0]    write_id,
  output logic               wren,
  output logic               busy,
  output logic               done,
  output logic [CW-1:0]      lines_cleared,
  output logic [HEIGHT-1:0]  clear_mask,
  output logic [TOTAL_W-1:0] total_lines
);

  localparam int SW = ((TOTAL_W > CW) ? TOTAL_W : CW) + 1;
  localparam logic [SW-1:0] TOT_MAX = {{(SW-TOTAL_W){1'b0}}, {TOTAL_W{1'b1}}};

  state_e state;
  logic   load, src_dec, dst_dec, cnt_inc, fill_load;
  logic   last_col, full_now, active;

  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      src_q, src_d, dst_q, dst_d;
  logic [CW-1:0]      cnt_q, cnt_d, fill_top;
  logic               row_full_q;
  logic [HEIGHT-1:0]  mask_q, mask_d;
  logic [CW-1:0]      lines_q;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [SW-1:0]      sum;

  assign last_col = (x_q == XW'(WIDTH - 1));
  // The AND chain restarts at column 0 so no explicit per-row clear is needed.
  assign full_now = ((x_q == '0) ? 1'b1 : row_full_q) & (read_id != ID_W'(EMPTY_ID));
  assign active   = (state == ST_CHECK) || (state == ST_COPY) || (state == ST_FILL);
  // Highest row to blank: cnt-1, counting a row cleared in this same cycle.
  assign fill_top = cnt_inc ? cnt_q : (cnt_q - CW'(1));
  assign sum      = SW'(total_q) + SW'(cnt_q);

  line_compactor_ctr u_ctr (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_i      (start),
    .last_col_i   (last_col),
    .row_full_i   (full_now),
    .src_zero_i   (src_q == '0),
    .src_eq_dst_i (src_q == dst_q),
    .cnt_zero_i   (cnt_q == '0),
    .state_o      (state),
    .load_o       (load),
    .src_dec_o    (src_dec),
    .dst_dec_o    (dst_dec),
    .cnt_inc_o    (cnt_inc),
    .fill_load_o  (fill_load)
  );

  // Datapath next-state: pointers, column, count, mask and accumulator.
  always_comb begin
    x_d     = x_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    total_d = total_q;
    if (load) begin
      x_d    = '0;
      src_d  = YW'(HEIGHT - 1);
      dst_d  = YW'(HEIGHT - 1);
      cnt_d  = '0;
      mask_d = '0;
    end else begin
      if (active) x_d = last_col ? '0 : x_q + XW'(1);
      // The source pointer is reused as the fill row pointer.
      if (fill_load)    src_d = fill_top[YW-1:0];
      else if (src_dec) src_d = src_q - YW'(1);
      if (dst_dec) dst_d = dst_q - YW'(1);
      if (cnt_inc) begin
        cnt_d         = cnt_q + CW'(1);
        mask_d[src_q] = 1'b1;
      end
      if (state == ST_DONE) total_d = (sum > TOT_MAX) ? TOT_MAX[TOTAL_W-1:0] : sum[TOTAL_W-1:0];
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q        <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      row_full_q <= 1'b0;
      mask_q     <= '0;
      lines_q    <= '0;
      total_q    <= '0;
    end else begin
      x_q     <= x_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      total_q <= total_d;
      if (state == ST_CHECK) row_full_q <= full_now;
      if (state == ST_DONE)  lines_q    <= cnt_q;
    end
  end

  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign wren          = (state == ST_COPY) || (state == ST_FILL);
  assign read_x        = (state == ST_IDLE) ? '0 : x_q;
  assign read_y        = (state == ST_IDLE) ? '0 : src_q;
  assign write_x       = wren ? x_q : '0;
  assign write_y       = (state == ST_COPY) ? dst_q : ((state == ST_FILL) ? src_q : '0);
  assign write_id      = (state == ST_COPY) ? read_id : '0;
  assign lines_cleared = lines_q;
  assign clear_mask    = mask_q;
  assign total_lines   = total_q;

endmodule

// File: tb/tb_line_compactor.sv
// Directed bench for line_compactor with a behavioural board RAM.
module tb_line_compactor;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int IW = 3;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [IW-1:0] read_id;
  logic [3:0]    read_x, write_x;
  logic [4:0]    read_y, write_y;
  logic [IW-1:0] write_id;
  logic          wren, busy, done;
  logic [4:0]    lines_cleared;
  logic [H-1:0]  clear_mask;
  logic [TW-1:0] total_lines;

  logic [IW-1:0] board [0:H-1][0:W-1];
  logic          tb_we, tb_clr;
  logic [4:0]    tb_y;
  logic [3:0]    tb_x;
  logic [IW-1:0] tb_d;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  line_compactor #(.WIDTH(W), .HEIGHT(H), .ID_W(IW), .TOTAL_W(TW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .read_id       (read_id),
    .read_x        (read_x),
    .read_y        (read_y),
    .write_x       (write_x),
    .write_y       (write_y),
    .write_id      (write_id),
    .wren          (wren),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .clear_mask    (clear_mask),
    .total_lines   (total_lines)
  );

  assign read_id = board[read_y][read_x];

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) board[r][c] <= '0;
    end else if (wren) begin
      board[write_y][write_x] <= write_id;
    end else if (tb_we) begin
      board[tb_y][tb_x] <= tb_d;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_board();
    @(negedge clk); tb_clr = 1'b1;
    @(posedge clk); #1 tb_clr = 1'b0;
  endtask

  task automatic put(input int y, input int x, input int d);
    @(negedge clk); tb_we = 1'b1; tb_y = 5'(y); tb_x = 4'(x); tb_d = IW'(d);
    @(posedge clk); #1 tb_we = 1'b0;
  endtask

  function automatic logic [63:0] row_bits(input int r);
    logic [63:0] v = '0;
    for (int c = 0; c < W; c++) v[c*3 +: 3] = board[r][c];
    return v;
  endfunction

  // Only row 19 full (ID 2); row k holds ID (k%7)+1 at x=0.
  task automatic setup_one();
    clr_board();
    for (int r = 0; r < H - 1; r++) put(r, 0, (r % 7) + 1);
    for (int c = 0; c < W; c++) put(H - 1, c, 2);
  endtask

  // Rows 19, 18, 16, 15 full (ID 1); row 17 holds ID 5 at x=3.
  task automatic setup_four();
    clr_board();
    for (int c = 0; c < W; c++) begin
      put(19, c, 1); put(18, c, 1); put(16, c, 1); put(15, c, 1);
    end
    put(17, 3, 5);
  endtask

  // Runs one pass; optionally pulses start again at busy cycle pulse_at.
  task automatic run_pass(input string name, input int pulse_at,
                          output int cycles, output int dones, output int wrens,
                          output logic last_done);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cycles = 0; dones = 0; wrens = 0; last_done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start = (i == pulse_at);
      if (!busy) break;
      cycles++;
      if (done) dones++;
      if (wren) wrens++;
      last_done = done;
    end
    start = 1'b0;
    $display("[TB] pass %s: busy=%0d done=%0d wren=%0d lines=%0d mask=%05h total=%0d",
             name, cycles, dones, wrens, lines_cleared, clear_mask, total_lines);
  endtask

  function automatic logic [63:0] out_vec();
    return {12'd0, busy, done, wren, write_x, write_y, write_id, read_x, read_y,
            lines_cleared, clear_mask, total_lines};
  endfunction

  int   cyc, dn, wr;
  logic ld;

  initial begin
    reset_n = 1'b0; start = 1'b0; tb_we = 1'b0; tb_clr = 1'b0;
    tb_x = '0; tb_y = '0; tb_d = '0;
    clr_board();
    repeat (2) @(negedge clk);
    chk("reset_outputs", out_vec(), 64'd0);
    reset_n = 1'b1;

    // Empty board.
    run_pass("empty", -1, cyc, dn, wr, ld);
    chk("empty_cycles", 64'(cyc), 64'd201);
    chk("empty_wren", 64'(wr), 64'd0);
    chk("empty_dones", 64'(dn), 64'd1);
    chk("empty_done_last", 64'(ld), 64'd1);
    chk("empty_lines", 64'(lines_cleared), 64'd0);
    chk("empty_mask", 64'(clear_mask), 64'd0);

    // Four full rows, one survivor with ID 5.
    setup_four();
    run_pass("four", -1, cyc, dn, wr, ld);
    chk("four_cycles", 64'(cyc), 64'd401);
    chk("four_lines", 64'(lines_cleared), 64'd4);
    chk("four_mask", 64'(clear_mask), 64'hD8000);
    chk("four_total", 64'(total_lines), 64'd4);
    for (int r = 0; r < H; r++)
      chk($sformatf("four_row%0d", r), row_bits(r), (r == 19) ? (64'd5 << 9) : 64'd0);

    // Single full bottom row; mask from the previous pass must be cleared.
    setup_one();
    run_pass("one", -1, cyc, dn, wr, ld);
    chk("one_cycles", 64'(cyc), 64'd401);
    chk("one_lines", 64'(lines_cleared), 64'd1);
    chk("one_mask", 64'(clear_mask), 64'h80000);
    chk("one_total", 64'(total_lines), 64'd5);
    for (int r = 0; r < H; r++)
      chk($sformatf("one_row%0d", r), row_bits(r), (r == 0) ? 64'd0 : 64'((r - 1) % 7 + 1));

    // Saturation (5+4 -> 7) with a start pulse while busy.
    setup_four();
    run_pass("sat", 50, cyc, dn, wr, ld);
    chk("sat_cycles", 64'(cyc), 64'd401);
    chk("sat_dones", 64'(dn), 64'd1);
    chk("sat_total", 64'(total_lines), 64'd7);
    @(negedge clk);
    chk("sat_no_restart", 64'(busy), 64'd0);
    setup_four();
    run_pass("sat2", -1, cyc, dn, wr, ld);
    chk("sat2_total", 64'(total_lines), 64'd7);

    // Reset during COPY (busy cycles 21-30 copy row 18 into row 19).
    setup_one();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (25) @(negedge clk);
    chk("rst_in_copy", 64'(wren), 64'd1);
    #1 reset_n = 1'b0;
    #1 chk("rst_outputs", out_vec(), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    chk("rst_idle", 64'(busy), 64'd0);
    setup_one();
    run_pass("after_rst", -1, cyc, dn, wr, ld);
    chk("rst_cycles", 64'(cyc), 64'd401);
    chk("rst_lines", 64'(lines_cleared), 64'd1);
    chk("rst_mask", 64'(clear_mask), 64'h80000);
    chk("rst_total", 64'(total_lines), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
